// File: rtl/cmul_pkg.sv
// cmul_pkg: shared widths, flag bundle and arithmetic helpers
// for the pipelined complex multiply-accumulate (cmul_mac_pipe).
package cmul_pkg;

  // Widest packed operand / intermediate the helpers handle.
  localparam int MAX_W = 128;

  typedef struct packed {
    logic first;
    logic last;
  } beat_flags_t;

  // Sign-extended component width.
  function automatic int ext_w(input int w);
    return w / 2 + 1;
  endfunction

  // Full-precision product width.
  function automatic int prod_w(input int w);
    return 2 * (w / 2 + 1);
  endfunction

  // Real part of a packed w-bit operand, sign-extended to MAX_W.
  function automatic logic signed [MAX_W-1:0] re_sx(
    input logic [MAX_W-1:0] x,
    input int               w
  );
    logic [MAX_W-1:0] t;
    t = x << (MAX_W - w / 2);
    return $signed(t) >>> (MAX_W - w / 2);
  endfunction

  // Imag part of a packed w-bit operand, sign-extended to MAX_W.
  function automatic logic signed [MAX_W-1:0] im_sx(
    input logic [MAX_W-1:0] x,
    input int               w
  );
    logic [MAX_W-1:0] t;
    t = x << (MAX_W - w);
    return $signed(t) >>> (MAX_W - w / 2);
  endfunction

  // Clamp v into the signed w-bit range.
  function automatic logic signed [MAX_W-1:0] sat_to(
    input logic signed [MAX_W-1:0] v,
    input int                      w
  );
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cmul_product_stage.sv
// cmul_product_stage: S2 of cmul_mac_pipe. Sign-extends the
// components, optionally conjugates b, registers four products.
// Ports: clk, en (advance), a/b packed operands, conj,
//   p_rr=ar*br, p_ii=ai*bi, p_ri=ar*bi, p_ir=ai*br.
module cmul_product_stage
  import cmul_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PROD_W = 2 * (WIDTH / 2 + 1)
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     conj,
  output logic signed [PROD_W-1:0] p_rr,
  output logic signed [PROD_W-1:0] p_ii,
  output logic signed [PROD_W-1:0] p_ri,
  output logic signed [PROD_W-1:0] p_ir
);

  localparam int EXT_W = ext_w(WIDTH);

  logic signed [EXT_W-1:0] ar, ai, br, bi, bi_c;
  logic signed [PROD_W-1:0] p_rr_d, p_ii_d;
  logic signed [PROD_W-1:0] p_ri_d, p_ir_d;
  logic signed [PROD_W-1:0] p_rr_q, p_ii_q;
  logic signed [PROD_W-1:0] p_ri_q, p_ir_q;

  always_comb begin
    ar = EXT_W'(re_sx(MAX_W'(a), WIDTH));
    ai = EXT_W'(im_sx(MAX_W'(a), WIDTH));
    br = EXT_W'(re_sx(MAX_W'(b), WIDTH));
    bi = EXT_W'(im_sx(MAX_W'(b), WIDTH));
    // One guard bit makes -(-2^(W/2-1)) exact.
    bi_c = conj ? -bi : bi;
    p_rr_d = PROD_W'(ar) * PROD_W'(br);
    p_ii_d = PROD_W'(ai) * PROD_W'(bi_c);
    p_ri_d = PROD_W'(ar) * PROD_W'(bi_c);
    p_ir_d = PROD_W'(ai) * PROD_W'(br);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ri_q <= p_ri_d;
      p_ir_q <= p_ir_d;
    end
  end

  assign p_rr = p_rr_q;
  assign p_ii = p_ii_q;
  assign p_ri = p_ri_q;
  assign p_ir = p_ir_q;

endmodule

// File: rtl/cmul_mac_pipe.sv
// cmul_mac_pipe: 3-stage complex multiply-accumulate, valid/ready
// on both sides. Optional saturation: define CMUL_MAC_SAT_EN.
// Ports: clk, rst (sync, active high); in_valid/in_ready,
//   in_a/in_b packed {imag,real}, in_conj, in_first, in_last;
//   out_valid/out_ready, out_result {imag,real} OUT_W each.
module cmul_mac_pipe
  import cmul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OUT_W = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_conj,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*OUT_W-1:0] out_result
);

  localparam int PROD_W = prod_w(WIDTH);
  localparam int S_W =
    ((PROD_W + 1 > OUT_W) ? PROD_W + 1 : OUT_W) + 1;

  logic en;

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_c_q, s1_c_d;
  beat_flags_t      s1_f_q, s1_f_d;

  logic        s2_v_q, s2_v_d;
  beat_flags_t s2_f_q, s2_f_d;

  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;

  logic signed [S_W-1:0] re_w, im_w;
  logic signed [S_W-1:0] re_p, im_p;
  logic signed [S_W-1:0] re_s, im_s;
  logic signed [OUT_W-1:0] re_n, im_n;

  logic signed [OUT_W-1:0] acc_re_q, acc_re_d;
  logic signed [OUT_W-1:0] acc_im_q, acc_im_d;
  logic             ov_q, ov_d;
  logic [OUT_W-1:0] res_re_q, res_re_d;
  logic [OUT_W-1:0] res_im_q, res_im_d;

  assign en = !ov_q | out_ready;

  cmul_product_stage #(
    .WIDTH  (WIDTH),
    .PROD_W (PROD_W)
  ) u_prod (
    .clk  (clk),
    .en   (en),
    .a    (s1_a_q),
    .b    (s1_b_q),
    .conj (s1_c_q),
    .p_rr (p_rr),
    .p_ii (p_ii),
    .p_ri (p_ri),
    .p_ir (p_ir)
  );

  always_comb begin
    re_w = S_W'(p_rr) - S_W'(p_ii);
    im_w = S_W'(p_ri) + S_W'(p_ir);
`ifdef CMUL_MAC_SAT_EN
    re_p = S_W'(sat_to(MAX_W'(re_w), OUT_W));
    im_p = S_W'(sat_to(MAX_W'(im_w), OUT_W));
`else
    re_p = re_w;
    im_p = im_w;
`endif
    re_s = s2_f_q.first ? re_p : S_W'(acc_re_q) + re_p;
    im_s = s2_f_q.first ? im_p : S_W'(acc_im_q) + im_p;
`ifdef CMUL_MAC_SAT_EN
    re_n = OUT_W'(sat_to(MAX_W'(re_s), OUT_W));
    im_n = OUT_W'(sat_to(MAX_W'(im_s), OUT_W));
`else
    re_n = OUT_W'(re_s);
    im_n = OUT_W'(im_s);
`endif
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_c_d   = s1_c_q;
    s1_f_d   = s1_f_q;
    s2_v_d   = s2_v_q;
    s2_f_d   = s2_f_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    ov_d     = ov_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    if (en) begin
      s1_v_d       = in_valid;
      s1_a_d       = in_a;
      s1_b_d       = in_b;
      s1_c_d       = in_conj;
      s1_f_d.first = in_first;
      s1_f_d.last  = in_last;
      s2_v_d       = s1_v_q;
      s2_f_d       = s1_f_q;
      ov_d         = s2_v_q & s2_f_q.last;
      // Bubbles leave the accumulator alone.
      if (s2_v_q) begin
        acc_re_d = re_n;
        acc_im_d = im_n;
        if (s2_f_q.last) begin
          res_re_d = re_n;
          res_im_d = im_n;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_c_q   <= 1'b0;
      s1_f_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_f_q   <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      ov_q     <= 1'b0;
      res_re_q <= '0;
      res_im_q <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_c_q   <= s1_c_d;
      s1_f_q   <= s1_f_d;
      s2_v_q   <= s2_v_d;
      s2_f_q   <= s2_f_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      ov_q     <= ov_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
    end
  end

  assign in_ready   = en;
  assign out_valid  = ov_q;
  assign out_result = {res_im_q, res_re_q};

endmodule

// File: tb/tb_cmul_mac_pipe.sv
// tb_cmul_mac_pipe: directed + random checks of cmul_mac_pipe
// against an arithmetic reference model (WIDTH=OUT_W=32).
module tb_cmul_mac_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_conj = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [63:0] last_out = '0;
  logic [63:0] exp_q[$];
  longint m_re = 0;
  longint m_im = 0;
  logic have_hold = 1'b0;
  logic [63:0] hold_val = '0;
  logic saw_stall = 1'b0;
  logic rnd = 1'b0;

  always #5 clk = ~clk;

  cmul_mac_pipe #(.WIDTH(32), .OUT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_conj    (in_conj),
    .in_first   (in_first),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint wrap32(input longint x);
    logic [63:0] t;
    t = x;
    return longint'($signed(t[31:0]));
  endfunction

  function automatic longint sat32(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic longint lim(input longint x);
`ifdef CMUL_MAC_SAT_EN
    return sat32(x);
`else
    return wrap32(x);
`endif
  endfunction

  // Reference: complex product from the definition, then
  // accumulate in OUT_W with wrap or saturation.
  task automatic model_beat(input logic [31:0] a, b,
                            input logic c, f, l);
    longint ar, ai, br, bi, re, im;
    logic [31:0] r32, i32;
    ar = longint'($signed(a[15:0]));
    ai = longint'($signed(a[31:16]));
    br = longint'($signed(b[15:0]));
    bi = longint'($signed(b[31:16]));
    if (c) bi = -bi;
    re = lim(ar * br - ai * bi);
    im = lim(ar * bi + ai * br);
    m_re = f ? re : lim(m_re + re);
    m_im = f ? im : lim(m_im + im);
    r32 = m_re[31:0];
    i32 = m_im[31:0];
    if (l) exp_q.push_back({i32, r32});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_re = 0;
      m_im = 0;
      have_hold = 1'b0;
    end else begin
      if (have_hold && out_valid)
        chk("stable_while_stalled", out_result, hold_val);
      have_hold = out_valid && !out_ready;
      hold_val = out_result;
      if (!in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready)
        model_beat(in_a, in_b, in_conj, in_first, in_last);
      if (out_valid && out_ready) begin
        n_out++;
        last_out = out_result;
        if (exp_q.size() == 0)
          chk("unexpected_output", {63'd0, out_valid}, 64'd0);
        else
          chk("result", out_result, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] a, b,
                      input logic c, f, l);
    bit ok;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_conj = c;
    in_first = f;
    in_last = l;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Checks latency (out_valid exactly two edges after accept edge)
  // and the value against a constant.
  task automatic single_chk(input string tag, input logic [31:0] a,
                            b, input logic c,
                            input logic [63:0] exp);
    send(a, b, c, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, "_early"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk(tag, out_result, exp);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_result", out_result, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    single_chk("mul", 32'h00040003, 32'h00020001, 1'b0,
               {32'd10, 32'hFFFFFFFB});
    single_chk("conj", 32'h00040003, 32'h00020001, 1'b1,
               {32'hFFFFFFFE, 32'd11});
`ifdef CMUL_MAC_SAT_EN
    single_chk("ovf", 32'h80008000, 32'h80008000, 1'b0,
               {32'h7FFFFFFF, 32'd0});
`else
    single_chk("ovf", 32'h80008000, 32'h80008000, 1'b0,
               {32'h80000000, 32'd0});
`endif
    single_chk("conj_min", 32'h00000001, 32'h80000000, 1'b1,
               {32'h00008000, 32'd0});

    n0 = n_out;
    send(32'h00010001, 32'h00010001, 1'b0, 1'b1, 1'b0);
    send(32'h00010001, 32'h00010001, 1'b0, 1'b0, 1'b0);
    send(32'h00010001, 32'h00010001, 1'b0, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("acc_count", 64'(n_out - n0), 64'd1);
    chk("acc_value", last_out, {32'd6, 32'd0});

    n0 = n_out;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)),
               1'b1, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(n_out - n0), 64'd10);
    chk("bp_in_ready_drop", {63'd0, saw_stall}, 64'd1);

    send(32'h00070005, 32'h00030002, 1'b0, 1'b1, 1'b0);
    send(32'h00070005, 32'h00030002, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    single_chk("rst_then", 32'h00010001, 32'h00010001, 1'b0,
               {32'd2, 32'd0});

    rnd = 1'b1;
    fork
      while (rnd) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send($urandom, $urandom, 1'($urandom_range(0, 1)),
           (i == 0) || ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0));
    end
    rnd = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
